dsp_countdown_seq: RTL and testbench

Loadable down-counting address sequencer for the TPU DSP datapath. It accepts a burst command (base address, stride, beat count) over a valid/ready handshake, then emits that many addresses on a valid/ready stream, counting the remaining beats down to zero. On the final beat it flags `addr_last` and pulses `done`. It pairs with `dsp_load_ctr` as the consuming side: `dsp_load_ctr` loads a start value and counts up freely, while this block loads a beat count and drains it to a terminal event, gated by the same style of `enable`.

---
 rtl/dsp_countdown_seq.sv | 103 ++++++++++
 tb/tb_dsp_countdown_seq.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/dsp_countdown_seq.sv
// Down-counting burst address sequencer: takes {base, stride, len}, emits len addresses and pulses done.
// First beat is valid the cycle after command accept (if enable); beats hold stable under addr_ready backpressure.
module dsp_countdown_seq #(
   parameter int ADDR_WIDTH = 32,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_WIDTH-1:0] cmd_base,
   input  logic [ADDR_WIDTH-1:0] cmd_stride,
   input  logic [LEN_WIDTH-1:0]  cmd_len,
   output logic                  addr_valid,
   input  logic                  addr_ready,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic                  addr_last,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t                state;
   state_t                state_nxt;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ADDR_WIDTH-1:0] stride_q;
   logic [LEN_WIDTH-1:0]  rem_q;
   logic                  addr_valid_q;
   logic                  done_q;

   logic cmd_fire;
   logic beat_fire;
   logic last_beat;
   logic len_zero;

   assign cmd_fire  = cmd_valid && (state == IDLE);
   assign beat_fire = addr_valid_q && addr_ready;
   assign last_beat = (rem_q == LEN_WIDTH'(1));
   assign len_zero  = (cmd_len == '0);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cmd_fire && !len_zero) state_nxt = RUN;
         RUN:     if (beat_fire && last_beat) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = (state == IDLE);
      busy      = (state == RUN);
   end

   // Datapath; addr_q/rem_q only move on a handshake so a presented beat never changes.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q       <= '0;
         stride_q     <= '0;
         rem_q        <= '0;
         addr_valid_q <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (cmd_fire) begin
            if (len_zero) begin
               done_q <= 1'b1;
            end else begin
               addr_q       <= cmd_base;
               stride_q     <= cmd_stride;
               rem_q        <= cmd_len;
               addr_valid_q <= enable;
            end
         end else if (state == RUN) begin
            if (beat_fire) begin
               addr_q <= addr_q + stride_q;
               rem_q  <= rem_q - LEN_WIDTH'(1);
               if (last_beat) begin
                  addr_valid_q <= 1'b0;
                  done_q       <= 1'b1;
               end else begin
                  addr_valid_q <= enable;
               end
            end else if (!addr_valid_q) begin
               addr_valid_q <= enable;
            end
         end
      end
   end

   assign addr       = addr_q;
   assign addr_valid = addr_valid_q;
   assign addr_last  = addr_valid_q && last_beat;
   assign done       = done_q;

endmodule

// File: tb/tb_dsp_countdown_seq.sv
// Directed bench for dsp_countdown_seq: inputs change and outputs are sampled on the falling edge.
module tb_dsp_countdown_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_base;
   logic [31:0] cmd_stride;
   logic [15:0] cmd_len;
   logic        addr_valid;
   logic        addr_ready;
   logic [31:0] addr;
   logic        addr_last;
   logic        busy;
   logic        done;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   dsp_countdown_seq #(.ADDR_WIDTH(32), .LEN_WIDTH(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_base   (cmd_base),
      .cmd_stride (cmd_stride),
      .cmd_len    (cmd_len),
      .addr_valid (addr_valid),
      .addr_ready (addr_ready),
      .addr       (addr),
      .addr_last  (addr_last),
      .busy       (busy),
      .done       (done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_chk(input string tag);
      chk({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
      chk({tag, ".addr_valid"}, 32'(addr_valid), 32'd0);
      chk({tag, ".busy"}, 32'(busy), 32'd0);
   endtask

   // Present a command for exactly one rising edge; returns at the following falling edge.
   task automatic send_cmd(input logic [31:0] b, input logic [31:0] s, input logic [15:0] l);
      cmd_valid  = 1'b1;
      cmd_base   = b;
      cmd_stride = s;
      cmd_len    = l;
      @(negedge clk);
      cmd_valid  = 1'b0;
   endtask

   // With enable and addr_ready high, expects len gap-free beats then the done cycle.
   task automatic burst_chk(input string tag, input logic [31:0] b, input logic [31:0] s, input int l);
      logic [31:0] a;
      a = b;
      for (int i = 0; i < l; i++) begin
         chk({tag, ".valid"}, 32'(addr_valid), 32'd1);
         chk({tag, ".addr"}, addr, a);
         chk({tag, ".last"}, 32'(addr_last), (i == l - 1) ? 32'd1 : 32'd0);
         chk({tag, ".busy"}, 32'(busy), 32'd1);
         a = a + s;
         @(negedge clk);
      end
      chk({tag, ".done"}, 32'(done), 32'd1);
      idle_chk({tag, ".end"});
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; cmd_valid = 1'b0; addr_ready = 1'b0;
      cmd_base = '0; cmd_stride = '0; cmd_len = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Reset and idle
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         idle_chk("rst_idle");
         chk("rst_idle.done", 32'(done), 32'd0);
         chk("rst_idle.addr", addr, 32'd0);
         chk("rst_idle.last", 32'(addr_last), 32'd0);
      end

      // Basic burst
      enable = 1'b1; addr_ready = 1'b1;
      send_cmd(32'h100, 32'd4, 16'd5);
      burst_chk("basic", 32'h100, 32'd4, 5);
      @(negedge clk);
      chk("basic.done_once", 32'(done), 32'd0);

      // Backpressure and enable gating
      addr_ready = 1'b0;
      send_cmd(32'h0, 32'd1, 16'd4);
      chk("bp.b0_valid", 32'(addr_valid), 32'd1);
      chk("bp.b0_addr", addr, 32'd0);
      addr_ready = 1'b1;
      @(negedge clk);
      addr_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("bp.stall_valid", 32'(addr_valid), 32'd1);
         chk("bp.stall_addr", addr, 32'd1);
         chk("bp.stall_last", 32'(addr_last), 32'd0);
         @(negedge clk);
      end
      chk("bp.b1_held", addr, 32'd1);
      addr_ready = 1'b1;
      @(negedge clk);
      chk("bp.b2_valid", 32'(addr_valid), 32'd1);
      chk("bp.b2_addr", addr, 32'd2);
      enable = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("bp.gap_valid", 32'(addr_valid), 32'd0);
         chk("bp.gap_addr", addr, 32'd3);
         chk("bp.gap_busy", 32'(busy), 32'd1);
         chk("bp.gap_done", 32'(done), 32'd0);
      end
      enable = 1'b1;
      @(negedge clk);
      chk("bp.b3_valid", 32'(addr_valid), 32'd1);
      chk("bp.b3_addr", addr, 32'd3);
      chk("bp.b3_last", 32'(addr_last), 32'd1);
      @(negedge clk);
      chk("bp.done", 32'(done), 32'd1);
      idle_chk("bp.end");
      @(negedge clk);

      // Zero length, then back-to-back bursts
      send_cmd(32'h5, 32'd1, 16'd0);
      chk("zero.done", 32'(done), 32'd1);
      idle_chk("zero");
      send_cmd(32'h20, 32'd8, 16'd2);
      burst_chk("b2b", 32'h20, 32'd8, 2);
      send_cmd(32'h40, 32'd4, 16'd2);
      burst_chk("b2b_third", 32'h40, 32'd4, 2);
      @(negedge clk);

      // Address wrap-around
      send_cmd(32'hFFFF_FFF8, 32'd8, 16'd3);
      burst_chk("wrap", 32'hFFFF_FFF8, 32'd8, 3);
      @(negedge clk);

      // Reset mid-burst; a command offered during reset is ignored
      send_cmd(32'h1000, 32'h10, 16'd10);
      chk("mid.b0_addr", addr, 32'h1000);
      repeat (2) @(negedge clk);
      chk("mid.b2_addr", addr, 32'h1020);
      rst = 1'b1;
      cmd_valid = 1'b1; cmd_base = 32'h77; cmd_len = 16'd3;
      @(negedge clk);
      idle_chk("mid.rst");
      chk("mid.rst_addr", addr, 32'd0);
      chk("mid.rst_done", 32'(done), 32'd0);
      rst = 1'b0; cmd_valid = 1'b0;
      @(negedge clk);
      idle_chk("mid.after");
      chk("mid.after_done", 32'(done), 32'd0);
      chk("mid.after_addr", addr, 32'd0);
      send_cmd(32'h55, 32'd1, 16'd1);
      burst_chk("mid.len1", 32'h55, 32'd1, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
